// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles big-endian words and writes them
// into instruction memory while holding the core in reset.
module imem_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] START_ADDR = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [31:0]           imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int LW = ADDR_WIDTH + 1;
    localparam logic [LW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } state_e;

    state_e         state_q, state_d;
    logic [LW-1:0]  len_q, len_d;
    logic [LW-1:0]  word_cnt_q, word_cnt_d;
    logic [1:0]     byte_cnt_q, byte_cnt_d;
    logic [23:0]    shift_q, shift_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           error_q, error_d;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        error_d    = error_q;
        unique case (state_q)
            IDLE: begin
                if (load_start) begin
                    if (load_len > DEPTH) begin
                        error_d = 1'b1;
                    end else begin
                        error_d = 1'b0;
                        if (load_len == '0) begin
                            state_d = DONE;
                        end else begin
                            len_d      = load_len;
                            word_cnt_d = '0;
                            byte_cnt_d = '0;
                            state_d    = RECV;
                        end
                    end
                end
            end
            RECV: begin
                if (byte_valid) begin
                    shift_d    = {shift_q[15:0], byte_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    // Fourth byte: latch the write bundle so it holds afterwards
                    if (byte_cnt_q == 2'd3) begin
                        wdata_d = {shift_q, byte_data};
                        addr_d  = START_ADDR + (32'(word_cnt_q) << 2);
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                word_cnt_d = word_cnt_q + LW'(1);
                if (word_cnt_q + LW'(1) == len_q) begin
                    state_d = DONE;
                end else begin
                    state_d = RECV;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            addr_q     <= START_ADDR;
            wdata_q    <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            error_q    <= error_d;
        end
    end

    assign byte_ready = (state_q == RECV);
    assign imem_we    = (state_q == WRITE);
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = (state_q == RECV) || (state_q == WRITE);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal, throttled, oversize, empty
// and aborted loads against hand-computed write traces.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic [8:0]  load_len;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    imem_loader #(.ADDR_WIDTH(8), .START_ADDR(32'h0)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .load_len   (load_len),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [63:0] wq[$];
    int done_cnt  = 0;
    int hold_bad  = 0;
    int lat_bad   = 0;
    int cyc       = 0;
    int acc_n     = 0;
    int last4     = 0;

    // Monitor samples on the falling edge, away from the active edge
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            acc_n = 0;
        end else begin
            if (byte_valid && byte_ready) begin
                acc_n = acc_n + 1;
                if (acc_n % 4 == 0) last4 = cyc;
            end
            if (imem_we) begin
                wq.push_back({imem_addr, imem_wdata});
                if (cyc != last4 + 1) lat_bad = lat_bad + 1;
            end
            if (done) begin
                done_cnt = done_cnt + 1;
                if (cpu_hold) hold_bad = hold_bad + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit ok = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (byte_ready) begin
                ok = 1;
                break;
            end
        end
        tick();
        chk("byte_accept", 32'(ok), 32'd1);
        if (gap) begin
            byte_valid = 1'b0;
            tick();
        end
    endtask

    task automatic start_load(input logic [8:0] len);
        load_start = 1'b1;
        load_len   = len;
        tick();
        load_start = 1'b0;
    endtask

    task automatic wait_done();
        bit got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
        end
        chk("done_seen", 32'(got), 32'd1);
        tick();
    endtask

    task automatic check_write(input string tag, input int idx,
                               input logic [31:0] a, input logic [31:0] d);
        logic [63:0] e;
        e = (idx < wq.size()) ? wq[idx] : 64'hFFFF_FFFF_FFFF_FFFF;
        chk({tag, "_addr"}, e[63:32], a);
        chk({tag, "_data"}, e[31:0], d);
    endtask

    logic [7:0] prog[8];

    task automatic two_word_load(input bit gap);
        wq.delete();
        done_cnt = 0;
        hold_bad = 0;
        lat_bad  = 0;
        chk("hold_before", 32'(cpu_hold), 32'd0);
        start_load(9'd2);
        chk("hold_after_start", 32'(cpu_hold), 32'd1);
        chk("busy_recv", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) send_byte(prog[i], gap);
        byte_valid = 1'b0;
        wait_done();
        chk("wr_count", 32'(wq.size()), 32'd2);
        check_write("w0", 0, 32'h0, 32'h2008_0005);
        check_write("w1", 1, 32'h4, 32'h3C01_1234);
        chk("done_cnt", 32'(done_cnt), 32'd1);
        chk("hold_in_done", 32'(hold_bad), 32'd0);
        chk("write_latency", 32'(lat_bad), 32'd0);
        chk("hold_after_done", 32'(cpu_hold), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        prog[0] = 8'h20; prog[1] = 8'h08; prog[2] = 8'h00; prog[3] = 8'h05;
        prog[4] = 8'h3C; prog[5] = 8'h01; prog[6] = 8'h12; prog[7] = 8'h34;
        reset      = 1'b1;
        load_start = 1'b0;
        load_len   = '0;
        byte_valid = 1'b0;
        byte_data  = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state and idle byte rejection
        chk("rst_ready", 32'(byte_ready), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_wdata", imem_wdata, 32'h0);
        wq.delete();
        byte_valid = 1'b1;
        byte_data  = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_ready", 32'(byte_ready), 32'd0);
        end
        tick();
        byte_valid = 1'b0;
        chk("idle_nowrite", 32'(wq.size()), 32'd0);

        two_word_load(1'b0);
        two_word_load(1'b1);

        // Oversize load is rejected and flagged
        wq.delete();
        start_load(9'd257);
        chk("err_set", 32'(error), 32'd1);
        chk("err_busy", 32'(busy), 32'd0);
        tick();
        chk("err_busy2", 32'(busy), 32'd0);
        chk("err_sticky", 32'(error), 32'd1);
        start_load(9'd1);
        chk("err_clear", 32'(error), 32'd0);
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        send_byte(8'hBE, 1'b0);
        send_byte(8'hEF, 1'b0);
        byte_valid = 1'b0;
        wait_done();
        chk("one_count", 32'(wq.size()), 32'd1);
        check_write("one", 0, 32'h0, 32'hDEAD_BEEF);

        // Empty load: immediate done, never holds the core
        wq.delete();
        done_cnt = 0;
        start_load(9'd0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_hold", 32'(cpu_hold), 32'd0);
        tick();
        chk("zero_done_off", 32'(done), 32'd0);
        chk("zero_busy", 32'(busy), 32'd0);
        chk("zero_nowrite", 32'(wq.size()), 32'd0);
        chk("zero_done_cnt", 32'(done_cnt), 32'd1);

        // Reset after six bytes of a three-word load
        wq.delete();
        start_load(9'd3);
        for (int i = 0; i < 6; i++) send_byte(8'h11 + 8'(i), 1'b0);
        byte_data = 8'h77;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        byte_valid = 1'b0;
        chk("abort_hold", 32'(cpu_hold), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        tick();
        tick();
        chk("abort_count", 32'(wq.size()), 32'd1);
        check_write("abort_w0", 0, 32'h0, 32'h1112_1314);
        wq.delete();
        start_load(9'd1);
        send_byte(8'hCA, 1'b1);
        send_byte(8'hFE, 1'b1);
        send_byte(8'hF0, 1'b1);
        send_byte(8'h0D, 1'b1);
        wait_done();
        chk("restart_count", 32'(wq.size()), 32'd1);
        check_write("restart", 0, 32'h0, 32'hCAFE_F00D);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
